// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multicycle MIPS control FSM that sequences the shared datapath's mux selects and write enables.
// Define MCPU_SLL_LUI_EN to add the sll (SHEX) and lui (LUIEX) execution paths.
module mcpu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_srca,
  output logic [2:0] alu_srcb,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_SHEX   = 4'd13,
    S_LUIEX  = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

`ifdef MCPU_SLL_LUI_EN
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [2:0] ALU_SLL = 3'b011;
`endif

  state_t     r_state;
  state_t     w_decode_next;
  logic [2:0] w_rtype_alu;
  logic       w_rtype_ok;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_rtype_ok  = 1'b1;
    w_rtype_alu = ALU_ADD;
    case (funct)
      FN_ADD:  w_rtype_alu = ALU_ADD;
      FN_SUB:  w_rtype_alu = ALU_SUB;
      FN_AND:  w_rtype_alu = ALU_AND;
      FN_OR:   w_rtype_alu = ALU_OR;
      FN_SLT:  w_rtype_alu = ALU_SLT;
      default: w_rtype_ok  = 1'b0;
    endcase
  end

  // Unsupported encodings fall back to FETCH; that fallback is exactly what flags illegal_op.
  always_comb begin
    w_decode_next = S_FETCH;
    case (op)
      OP_LW, OP_SW: w_decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (w_rtype_ok) w_decode_next = S_EXEC;
`ifdef MCPU_SLL_LUI_EN
        else if (funct == FN_SLL) w_decode_next = S_SHEX;
`endif
      end
      OP_BEQ:  w_decode_next = S_BRANCH;
      OP_ADDI: w_decode_next = S_ADDIEX;
      OP_J:    w_decode_next = S_JUMP;
`ifdef MCPU_SLL_LUI_EN
      OP_LUI:  w_decode_next = S_LUIEX;
`endif
      default: w_decode_next = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_decode_next;
        S_MEMADR: begin
          if (op == OP_SW) r_state <= S_MEMWR;
          else             r_state <= S_MEMRD;
        end
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_IWB;
`ifdef MCPU_SLL_LUI_EN
        S_SHEX:   r_state <= S_ALUWB;
        S_LUIEX:  r_state <= S_IWB;
`endif
        S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_srca   = 2'b00;
    alu_srcb   = 3'b000;
    alu_ctrl   = ALU_ADD;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_IDLE: alu_ctrl = 3'b000;
      S_FETCH: begin
        mem_read = 1'b1;
        alu_srcb = 3'b001;
        ir_write = mem_ready;
        pc_en    = mem_ready;
      end
      S_DECODE: begin
        alu_srcb   = 3'b011;
        illegal_op = (w_decode_next == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_srca = 2'b01;
        alu_srcb = 3'b010;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_srca = 2'b01;
        alu_ctrl = w_rtype_alu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_srca = 2'b01;
        alu_ctrl = ALU_SUB;
        pc_src   = 2'b01;
        pc_en    = zero;
      end
      S_IWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
`ifdef MCPU_SLL_LUI_EN
      S_SHEX: begin
        alu_srca = 2'b10;
        alu_ctrl = ALU_SLL;
      end
      S_LUIEX: begin
        alu_srca = 2'b11;
        alu_srcb = 3'b100;
      end
`endif
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: randomized check of mcpu_ctrl against a per-instruction cycle script built from the
// instruction's class, its memory wait counts and the branch flag.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_srca;
  logic [2:0] alu_srcb;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  mcpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

`ifdef MCPU_SLL_LUI_EN
  localparam bit HAS_EXT = 1'b1;
`else
  localparam bit HAS_EXT = 1'b0;
`endif

  typedef struct packed {
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_srca;
    logic [2:0] alu_srcb;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_en, illegal_op;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
  } cyc_t;

  typedef enum {C_LW, C_SW, C_R, C_SLL, C_BEQ, C_ADDI, C_J, C_LUI, C_ILL} cls_t;

  outs_t w_obs;
  assign w_obs = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_srca, alu_srcb, alu_ctrl, pc_src, pc_en, illegal_op};

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cycle  = 0;
  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, n_cycle, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      6'b001111: return HAS_EXT ? C_LUI : C_ILL;
      6'b000000: begin
        if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return C_R;
        if (f == 6'b000000 && HAS_EXT) return C_SLL;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic outs_t quiet();
    outs_t o;
    o = '0;
    o.alu_ctrl = 3'b010;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [3:0] st, input outs_t o, input logic rdy, input logic z,
                               input logic [5:0] opc, input logic [5:0] fn);
    cyc_t c;
    c.st = st; c.o = o; c.rdy = rdy; c.z = z; c.op = opc; c.fn = fn;
    q.push_back(c);
  endfunction

  function automatic void push_idle();
    push(4'd0, outs_t'(0), rbit(), rbit(), 6'($urandom), 6'($urandom));
  endfunction

  // Wait-state memory phase: 'waits' cycles of mem_ready low, then one completing cycle.
  function automatic void mem_phase(input logic [3:0] st, input outs_t o, input int waits,
                                    input logic [5:0] opc, input logic [5:0] fn);
    for (int i = 0; i < waits; i++) push(st, o, 1'b0, rbit(), opc, fn);
    push(st, o, 1'b1, rbit(), opc, fn);
  endfunction

  function automatic void add_instr(input logic [5:0] opc, input logic [5:0] fn,
                                    input int fw, input int mw, input logic z);
    outs_t o;
    cls_t  c;
    c = classify(opc, fn);
    o = quiet(); o.mem_read = 1'b1; o.alu_srcb = 3'b001;
    for (int i = 0; i < fw; i++) push(4'd1, o, 1'b0, rbit(), opc, fn);
    o.ir_write = 1'b1; o.pc_en = 1'b1;
    push(4'd1, o, 1'b1, rbit(), opc, fn);
    o = quiet(); o.alu_srcb = 3'b011; o.illegal_op = (c == C_ILL);
    push(4'd2, o, rbit(), rbit(), opc, fn);
    case (c)
      C_LW, C_SW: begin
        o = quiet(); o.alu_srca = 2'b01; o.alu_srcb = 3'b010;
        push(4'd3, o, rbit(), rbit(), opc, fn);
        o = quiet(); o.iord = 1'b1;
        if (c == C_LW) begin
          o.mem_read = 1'b1;
          mem_phase(4'd4, o, mw, opc, fn);
          o = quiet(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push(4'd5, o, rbit(), rbit(), opc, fn);
        end else begin
          o.mem_write = 1'b1;
          mem_phase(4'd6, o, mw, opc, fn);
        end
      end
      C_R, C_SLL: begin
        o = quiet();
        if (c == C_R) begin
          o.alu_srca = 2'b01; o.alu_ctrl = funct_alu(fn);
          push(4'd7, o, rbit(), rbit(), opc, fn);
        end else begin
          o.alu_srca = 2'b10; o.alu_ctrl = 3'b011;
          push(4'd13, o, rbit(), rbit(), opc, fn);
        end
        o = quiet(); o.reg_write = 1'b1; o.reg_dst = 1'b1;
        push(4'd8, o, rbit(), rbit(), opc, fn);
      end
      C_BEQ: begin
        o = quiet(); o.alu_srca = 2'b01; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.pc_en = z;
        push(4'd9, o, rbit(), z, opc, fn);
      end
      C_ADDI, C_LUI: begin
        o = quiet();
        if (c == C_ADDI) begin
          o.alu_srca = 2'b01; o.alu_srcb = 3'b010;
          push(4'd10, o, rbit(), rbit(), opc, fn);
        end else begin
          o.alu_srca = 2'b11; o.alu_srcb = 3'b100;
          push(4'd14, o, rbit(), rbit(), opc, fn);
        end
        o = quiet(); o.reg_write = 1'b1;
        push(4'd11, o, rbit(), rbit(), opc, fn);
      end
      C_J: begin
        o = quiet(); o.pc_src = 2'b10; o.pc_en = 1'b1;
        push(4'd12, o, rbit(), rbit(), opc, fn);
      end
      default: ;
    endcase
  endfunction

  // Inputs change on the falling edge; outputs are compared 1 time unit later.
  task automatic run(input int n);
    cyc_t c;
    repeat (n) begin
      c = q.pop_front();
      op = c.op; funct = c.fn; mem_ready = c.rdy; zero = c.z;
      #1;
      check("state", 32'(state), 32'(c.st));
      check("outputs", 32'(w_obs), 32'(c.o));
      n_cycle++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_outputs"}, 32'(w_obs), 32'd0);
  endtask

  task automatic add_random();
    logic [5:0] fns[7];
    logic [5:0] opc;
    logic [5:0] fn;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
    fn = 6'($urandom);
    case ($urandom_range(0, 8))
      0: opc = 6'b100011;
      1: opc = 6'b101011;
      2, 3: begin opc = 6'b000000; fn = fns[$urandom_range(0, 6)]; end
      4: opc = 6'b000100;
      5: opc = 6'b001000;
      6: opc = 6'b000010;
      7: opc = 6'b001111;
      default: opc = 6'($urandom);
    endcase
    add_instr(opc, fn, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
  endtask

  initial begin
    // Reset held: outputs must stay zero regardless of inputs or edges.
    op = 6'b100011; mem_ready = 1'b1; zero = 1'b1;
    #3;
    check_reset("reset");
    @(negedge clk);
    check_reset("reset_held");
    rst_n = 1'b1;

    push_idle();
    add_instr(6'b100011, 6'h00, 2, 1, 1'b0);       // lw, 8 cycles
    add_instr(6'b000100, 6'h00, 0, 0, 1'b1);       // beq taken
    add_instr(6'b000100, 6'h00, 0, 0, 1'b0);       // beq not taken
    add_instr(6'b000000, 6'b100010, 0, 0, 1'b0);   // sub
    add_instr(6'b000000, 6'b000000, 0, 0, 1'b0);   // sll
    add_instr(6'b111111, 6'h15, 0, 0, 1'b0);       // illegal
    add_instr(6'b001111, 6'h00, 1, 0, 1'b0);       // lui
    add_instr(6'b000010, 6'h00, 0, 0, 1'b0);       // j
    add_instr(6'b001000, 6'h00, 0, 0, 1'b0);       // addi
    add_instr(6'b101011, 6'h00, 0, 2, 1'b0);       // sw with stalls
    for (int i = 0; i < 150; i++) add_random();
    run(q.size());

    // sw stalled in MEMWR, then asynchronous reset between clock edges.
    add_instr(6'b101011, 6'h00, 0, 3, 1'b0);
    run(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", 32'(mem_write), 32'd0);
    check_reset("async_rst");
    q.delete();
    mem_ready = 1'b1;
    @(negedge clk);
    check_reset("async_rst_held");
    rst_n = 1'b1;

    push_idle();
    add_instr(6'b000000, 6'b101010, 0, 0, 1'b0);   // slt
    add_instr(6'b100011, 6'h00, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++) add_random();
    run(q.size());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
